// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the byte-wide memory controller.
// Serves RAM bytes with one cycle of read latency. Addresses with
// mem_a[17:16]==2'b11 decode to an IO window that holds an output FIFO,
// a status byte and a simulation-halt strobe.
// Optional feature: define MEM_RESP_CYCLE_CNT_EN to add a 32-bit cycle counter
// that can be read through IO offsets 0x8..0xB.
module mem_responder #(
  parameter int RAM_ADDR_WID  = 17,
  parameter int FIFO_DEPTH    = 16,
  parameter int FULL_HEADROOM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  output logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        sim_halt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HEADROOM_C = CW'(FULL_HEADROOM);

  // Address decode and access qualifiers
  logic                    is_io;
  logic [15:0]             io_off;
  logic [RAM_ADDR_WID-1:0] ram_idx;
  logic                    rd_en;
  logic                    wr_en;
  logic                    ram_we;
  logic                    push_req;
  logic                    halt_req;
  logic                    unused_addr;

  assign is_io       = (mem_a[17:16] == 2'b11);
  assign io_off      = mem_a[15:0];
  assign ram_idx     = mem_a[RAM_ADDR_WID-1:0];
  assign rd_en       = rdy & ~mem_wr;
  assign wr_en       = rdy & mem_wr;
  assign ram_we      = wr_en & ~is_io;
  assign push_req    = wr_en & is_io & (io_off == 16'h0000);
  assign halt_req    = wr_en & is_io & (io_off == 16'h0004);
  // The upper address bits are ignored by the decode.
  assign unused_addr = ^mem_a;

  // RAM storage and read-port registers
  logic [7:0] ram [0:(1 << RAM_ADDR_WID) - 1];
  logic [7:0] ram_q;
  logic       rd_sel;
  logic [7:0] io_q;
  logic [7:0] io_rdata;

  // FIFO state
  logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] free_next;
  logic          overflow;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;

`ifdef MEM_RESP_CYCLE_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] cyc_snap;

  // Free-running cycle counter, snapshotted when its low byte is read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= 32'd0;
      cyc_snap <= 32'd0;
    end else begin
      if (rdy)
        cyc_cnt <= cyc_cnt + 32'd1;
      if (rd_en && is_io && io_off == 16'h0008)
        cyc_snap <= cyc_cnt;
    end
  end
`endif

  // RAM write port plus a read-before-write read port (no reset on storage)
  always_ff @(posedge clk) begin
    if (ram_we)
      ram[ram_idx] <= mem_din;
    if (rd_en && !is_io)
      ram_q <= ram[ram_idx];
  end

  // IO read value for the currently presented address
  always_comb begin
    io_rdata = 8'h00;
    case (io_off)
      16'h0004: io_rdata = {overflow, 7'(count)};
`ifdef MEM_RESP_CYCLE_CNT_EN
      16'h0008: io_rdata = cyc_cnt[7:0];
      16'h0009: io_rdata = cyc_snap[15:8];
      16'h000A: io_rdata = cyc_snap[23:16];
      16'h000B: io_rdata = cyc_snap[31:24];
`endif
      default:  io_rdata = 8'h00;
    endcase
  end

  // Read source select and IO read byte; both hold when no read happens
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel <= 1'b0;
      io_q   <= 8'h00;
    end else if (rd_en) begin
      rd_sel <= ~is_io;
      if (is_io)
        io_q <= io_rdata;
    end
  end

  assign mem_dout = rd_sel ? ram_q : io_q;

  // FIFO handshakes: a pop frees a slot for a same-cycle push into a full FIFO
  assign tx_valid  = (count != '0);
  assign pop       = tx_valid & tx_ready;
  assign fifo_full = (count == DEPTH_C);
  assign push_ok   = push_req & (~fifo_full | pop);
  assign tx_data   = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  // Next occupancy and the near-full threshold derived from it
  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    free_next = DEPTH_C - count_next;
  end

  // FIFO storage (no reset; only occupied slots are ever observed)
  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= mem_din;
  end

  // FIFO pointers, occupancy, sticky overflow, backpressure and halt pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow       <= 1'b0;
      io_buffer_full <= 1'b0;
      sim_halt       <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push_req && fifo_full && !pop)
        overflow <= 1'b1;
      count          <= count_next;
      io_buffer_full <= (free_next <= HEADROOM_C);
      sim_halt       <= halt_req;
    end
  end

endmodule
